// File: rtl/ad9364_pkg.sv
// Shared types and constants for the AD9364 transmit sample scheduler.
package ad9364_pkg;

    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned BUS_W    = 4 * SAMPLE_W;

    typedef enum logic [1:0] {
        SRC_FIFO = 2'd0,
        SRC_PAT  = 2'd1,
        SRC_RAMP = 2'd2,
        SRC_ZERO = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Last slot index of a sample period: P-1 with P = 2 (1R1T) or 4 (2R2T).
    function automatic logic [1:0] slot_last(input logic r1);
        return r1 ? 2'd1 : 2'd3;
    endfunction

endpackage

// File: rtl/ad9364_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read, occupancy count and flush.
module ad9364_sync_fifo
    import ad9364_pkg::*;
#(
    parameter int unsigned FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [BUS_W-1:0]   wr_data,
    input  logic               rd_en,
    output logic [BUS_W-1:0]   rd_data,
    output logic [FIFO_AW:0]   count,
    output logic               full,
    output logic               empty
);

    localparam int unsigned     Depth    = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DepthCnt = (FIFO_AW + 1)'(Depth);

    logic [BUS_W-1:0]   mem_q [Depth];
    logic [FIFO_AW-1:0] wptr_q, wptr_d;
    logic [FIFO_AW-1:0] rptr_q, rptr_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic               wr_ok, rd_ok, mem_we;
    logic [FIFO_AW-1:0] mem_waddr;

    assign full    = (cnt_q == DepthCnt);
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rd_data = mem_q[rptr_q];

    // A write into a full FIFO is legal only when a read frees the slot in the same cycle.
    assign wr_ok = wr_en && (!full || rd_en);
    assign rd_ok = rd_en && !empty;

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        mem_we    = wr_ok;
        mem_waddr = wptr_q;
        if (flush) begin
            // Flush discards content but keeps a coincident write as the new head.
            rptr_d    = '0;
            mem_we    = wr_en;
            mem_waddr = '0;
            wptr_d    = wr_en ? FIFO_AW'(1) : '0;
            cnt_d     = wr_en ? (FIFO_AW + 1)'(1) : '0;
        end else begin
            if (wr_ok) wptr_d = wptr_q + FIFO_AW'(1);
            if (rd_ok) rptr_d = rptr_q + FIFO_AW'(1);
            unique case ({wr_ok, rd_ok})
                2'b10:   cnt_d = cnt_q + (FIFO_AW + 1)'(1);
                2'b01:   cnt_d = cnt_q - (FIFO_AW + 1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= wr_data;
    end

endmodule

// File: rtl/ad9364_dac_sched.sv
// Transmit sample scheduler for the AD9364 dac_* port group: buffers upstream samples
// and issues them on a fixed 2- or 4-clock cadence from a selectable source.
module ad9364_dac_sched
    import ad9364_pkg::*;
#(
    parameter int unsigned FIFO_AW        = 3,
    parameter int unsigned PRIME_LEVEL    = 4,
    parameter bit          UNDERFLOW_ZERO = 1'b1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                enable,
    input  logic                r1_mode,
    input  logic [1:0]          src_sel,
    input  logic [BUS_W-1:0]    pat_data,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [BUS_W-1:0]    s_data,
    output logic                dac_valid,
    output logic [SAMPLE_W-1:0] dac_data_i1,
    output logic [SAMPLE_W-1:0] dac_data_q1,
    output logic [SAMPLE_W-1:0] dac_data_i2,
    output logic [SAMPLE_W-1:0] dac_data_q2,
    output logic                dac_r1_mode,
    output logic                running,
    output logic                underflow,
    input  logic                underflow_clr,
    output logic [15:0]         underflow_cnt
);

    localparam logic [FIFO_AW:0] PrimeLvl = (FIFO_AW + 1)'(PRIME_LEVEL);

    state_e              state_q, state_d;
    logic [1:0]          slot_q, slot_d;
    logic [SAMPLE_W-1:0] ramp_q, ramp_d;
    logic                r1_q, r1_d;
    src_e                src_q, src_d;
    logic                dac_valid_q, dac_valid_d;
    logic [BUS_W-1:0]    dac_data_q, dac_data_d;
    logic                dac_r1_mode_q;
    logic                underflow_q, underflow_d;
    logic [15:0]         uf_cnt_q, uf_cnt_d;

    logic                flush, strobe, pop, push, uf_evt;
    logic [BUS_W-1:0]    fifo_rdata;
    logic [FIFO_AW:0]    fifo_count;
    logic                fifo_full, fifo_empty;
    logic [1:0]          last_slot;

    assign push      = s_valid && s_ready;
    assign s_ready   = !fifo_full;
    assign last_slot = slot_last(r1_q);

    ad9364_sync_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (flush),
        .wr_en   (push),
        .wr_data (s_data),
        .rd_en   (pop),
        .rd_data (fifo_rdata),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        ramp_d  = ramp_q;
        r1_d    = r1_q;
        src_d   = src_q;
        flush   = 1'b0;
        strobe  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                slot_d = '0;
                if (enable) begin
                    state_d = ST_PRIME;
                    r1_d    = r1_mode;
                    src_d   = src_e'(src_sel);
                    flush   = 1'b1;
                    ramp_d  = '0;
                end
            end
            ST_PRIME: begin
                slot_d = '0;
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (src_q != SRC_FIFO || fifo_count >= PrimeLvl) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                strobe = (slot_q == 2'd0);
                slot_d = (slot_q == last_slot) ? 2'd0 : slot_q + 2'd1;
                // Stopping on the last slot already completes the period.
                if (!enable) state_d = (slot_q == last_slot) ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (slot_q == last_slot) begin
                    state_d = ST_IDLE;
                    slot_d  = '0;
                end else begin
                    slot_d = slot_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (strobe && src_q == SRC_RAMP) ramp_d = ramp_q + SAMPLE_W'(1);
    end

    always_comb begin
        dac_valid_d = strobe;
        dac_data_d  = dac_data_q;
        pop         = strobe && (src_q == SRC_FIFO) && !fifo_empty;
        uf_evt      = strobe && (src_q == SRC_FIFO) && fifo_empty;
        if (strobe) begin
            unique case (src_q)
                SRC_FIFO: begin
                    if (!fifo_empty)         dac_data_d = fifo_rdata;
                    else if (UNDERFLOW_ZERO) dac_data_d = '0;
                end
                SRC_PAT:  dac_data_d = pat_data;
                SRC_RAMP: dac_data_d = {~ramp_q, ramp_q, ~ramp_q, ramp_q};
                default:  dac_data_d = '0;
            endcase
        end
    end

    // A clear coinciding with a new underflow loses: the new event is recorded.
    always_comb begin
        underflow_d = underflow_q;
        uf_cnt_d    = uf_cnt_q;
        if (underflow_clr) begin
            underflow_d = 1'b0;
            uf_cnt_d    = '0;
        end
        if (uf_evt) begin
            underflow_d = 1'b1;
            if (underflow_clr)              uf_cnt_d = 16'd1;
            else if (uf_cnt_q != 16'hFFFF)  uf_cnt_d = uf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            slot_q        <= '0;
            ramp_q        <= '0;
            r1_q          <= 1'b1;
            src_q         <= SRC_FIFO;
            dac_valid_q   <= 1'b0;
            dac_data_q    <= '0;
            dac_r1_mode_q <= 1'b1;
            underflow_q   <= 1'b0;
            uf_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            ramp_q        <= ramp_d;
            r1_q          <= r1_d;
            src_q         <= src_d;
            dac_valid_q   <= dac_valid_d;
            dac_data_q    <= dac_data_d;
            dac_r1_mode_q <= r1_q;
            underflow_q   <= underflow_d;
            uf_cnt_q      <= uf_cnt_d;
        end
    end

    assign dac_valid     = dac_valid_q;
    assign dac_data_i1   = dac_data_q[SAMPLE_W-1:0];
    assign dac_data_q1   = dac_data_q[2*SAMPLE_W-1:SAMPLE_W];
    assign dac_data_i2   = dac_data_q[3*SAMPLE_W-1:2*SAMPLE_W];
    assign dac_data_q2   = dac_data_q[4*SAMPLE_W-1:3*SAMPLE_W];
    assign dac_r1_mode   = dac_r1_mode_q;
    assign running       = (state_q == ST_RUN);
    assign underflow     = underflow_q;
    assign underflow_cnt = uf_cnt_q;

endmodule

// File: tb/tb_ad9364_dac_sched.sv
// Scoreboard bench for ad9364_dac_sched: stimulus queues expected samples, a monitor
// pops and compares on every dac_valid strobe and checks the strobe cadence.
module tb_ad9364_dac_sched;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable, r1_mode, s_valid, underflow_clr;
    logic [1:0]  src_sel;
    logic [47:0] pat_data, s_data;
    logic        s_ready, dac_valid, dac_r1_mode, running, underflow;
    logic [11:0] dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2;
    logic [15:0] underflow_cnt;

    always #5 clk = ~clk;

    ad9364_dac_sched #(
        .FIFO_AW        (3),
        .PRIME_LEVEL    (4),
        .UNDERFLOW_ZERO (1'b1)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .enable        (enable),
        .r1_mode       (r1_mode),
        .src_sel       (src_sel),
        .pat_data      (pat_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .dac_valid     (dac_valid),
        .dac_data_i1   (dac_data_i1),
        .dac_data_q1   (dac_data_q1),
        .dac_data_i2   (dac_data_i2),
        .dac_data_q2   (dac_data_q2),
        .dac_r1_mode   (dac_r1_mode),
        .running       (running),
        .underflow     (underflow),
        .underflow_clr (underflow_clr),
        .underflow_cnt (underflow_cnt)
    );

    logic [47:0] sb [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          last_cyc = 0;
    bit          last_ok = 1'b0;
    int          per_chk = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] mk(input logic [11:0] i1, input logic [11:0] q1,
                                       input logic [11:0] i2, input logic [11:0] q2);
        return {q2, i2, q1, i1};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the head of the scoreboard and keep the cadence.
    always @(negedge clk) begin
        logic [47:0] got;
        logic [47:0] exp;
        if (rstn && dac_valid) begin
            got = {dac_data_q2, dac_data_i2, dac_data_q1, dac_data_i1};
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: got %h with no sample expected (t=%0t)",
                         got, $time);
            end else begin
                exp = sb.pop_front();
                chk("strobe_data", 64'(got), 64'(exp));
            end
            if (per_chk != 0 && last_ok) chk("cadence", 64'(cyc - last_cyc), 64'(per_chk));
            last_cyc = cyc;
            last_ok  = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [47:0] d);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    // Returns just after the monitor has consumed the last expected sample.
    task automatic wait_empty(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic start_run(input logic r1, input logic [1:0] src, input int period);
        r1_mode = r1;
        src_sel = src;
        per_chk = period;
        last_ok = 1'b0;
        enable  = 1'b1;
    endtask

    initial begin
        int n_strobe;
        rstn          = 1'b0;
        enable        = 1'b0;
        r1_mode       = 1'b1;
        src_sel       = 2'd0;
        pat_data      = '0;
        s_valid       = 1'b0;
        s_data        = '0;
        underflow_clr = 1'b0;
        tick(3);
        chk("rst_s_ready",   64'(s_ready), 64'd1);
        chk("rst_dac_valid", 64'(dac_valid), 64'd0);
        chk("rst_dac_data",  64'({dac_data_q2, dac_data_i2, dac_data_q1, dac_data_i1}), 64'd0);
        chk("rst_r1_mode",   64'(dac_r1_mode), 64'd1);
        chk("rst_running",   64'(running), 64'd0);
        chk("rst_underflow", 64'(underflow), 64'd0);
        chk("rst_uf_cnt",    64'(underflow_cnt), 64'd0);
        #2 rstn = 1'b1;
        tick(2);

        // 1R1T FIFO mode: 8 samples, RUN after the 4th push, strobe every 2 clk.
        for (int i = 1; i <= 8; i++)
            sb.push_back(mk(12'(i), 12'(12'hC00 + i), 12'(12'hB00 + i), 12'(12'hA00 + i)));
        start_run(1'b1, 2'd0, 2);
        tick(1);
        for (int i = 1; i <= 8; i++) begin
            chk("fifo_s_ready", 64'(s_ready), 64'd1);
            push(mk(12'(i), 12'(12'hC00 + i), 12'(12'hB00 + i), 12'(12'hA00 + i)));
            if (i == 4) chk("prime_not_run", 64'(running), 64'd0);
            if (i == 5) chk("run_after_prime", 64'(running), 64'd1);
            if (i == 6) chk("first_strobe", 64'(dac_valid), 64'd1);
            if (i == 7) chk("strobe_gap", 64'(dac_valid), 64'd0);
        end
        wait_empty(64);
        enable = 1'b0;
        tick(4);
        chk("r1_no_underflow", 64'(underflow), 64'd0);
        chk("r1_no_uf_cnt",    64'(underflow_cnt), 64'd0);

        // 2R2T pattern mode, then stop at slot 1 and drain.
        pat_data = 48'h5DF_484_7EB_434;
        for (int i = 0; i < 6; i++) sb.push_back(mk(12'h434, 12'h7EB, 12'h484, 12'h5DF));
        start_run(1'b0, 2'd1, 4);
        wait_empty(100);
        chk("r2_dac_r1_mode", 64'(dac_r1_mode), 64'd0);
        enable = 1'b0;
        tick(1);
        chk("drain_not_running", 64'(running), 64'd0);
        n_strobe = 0;
        for (int i = 0; i < 8; i++) begin
            if (dac_valid) n_strobe++;
            tick(1);
        end
        chk("drain_no_strobe", 64'(n_strobe), 64'd0);
        chk("drain_data_held", 64'({dac_data_q2, dac_data_i2, dac_data_q1, dac_data_i1}),
            64'(48'h5DF_484_7EB_434));

        // Junk written while IDLE must be flushed on re-enable; then underflow after 4.
        for (int i = 0; i < 3; i++) push(mk(12'hEEE, 12'hEEE, 12'hEEE, 12'hEEE));
        for (int i = 1; i <= 4; i++) sb.push_back(mk(12'(12'h100 + i), 12'h0F0, 12'h0, 12'h0));
        for (int i = 0; i < 3; i++) sb.push_back(48'h0);
        start_run(1'b1, 2'd0, 2);
        tick(1);
        for (int i = 1; i <= 4; i++) begin
            push(mk(12'(12'h100 + i), 12'h0F0, 12'h0, 12'h0));
            if (i == 3) chk("flush_not_run", 64'(running), 64'd0);
        end
        wait_empty(64);
        chk("uf_flag", 64'(underflow), 64'd1);
        chk("uf_cnt3", 64'(underflow_cnt), 64'd3);
        sb.push_back(48'h0);
        tick(1);
        underflow_clr = 1'b1;
        tick(1);
        underflow_clr = 1'b0;
        enable        = 1'b0;
        chk("uf_clr_set_wins_cnt", 64'(underflow_cnt), 64'd1);
        chk("uf_clr_set_wins_flag", 64'(underflow), 64'd1);
        tick(4);
        chk("uf_persist_idle", 64'(underflow_cnt), 64'd1);
        underflow_clr = 1'b1;
        tick(1);
        underflow_clr = 1'b0;
        chk("uf_clr_cnt",  64'(underflow_cnt), 64'd0);
        chk("uf_clr_flag", 64'(underflow), 64'd0);
        chk("uf_sb_left",  64'(sb.size()), 64'd0);

        // Ramp: 4097 strobes, wraps 0xFFF -> 0x000, q = ~i.
        for (int k = 0; k <= 4096; k++) begin
            logic [11:0] r;
            r = 12'(k);
            sb.push_back(mk(r, ~r, r, ~r));
        end
        start_run(1'b1, 2'd2, 2);
        wait_empty(9000);
        enable = 1'b0;
        tick(4);

        // Async reset mid-RUN with 5 FIFO entries.
        start_run(1'b0, 2'd0, 4);
        tick(1);
        for (int i = 1; i <= 6; i++) push(mk(12'(12'h200 + i), 12'h0, 12'h0, 12'h0));
        chk("pre_rst_running", 64'(running), 64'd1);
        #2 rstn = 1'b0;
        enable = 1'b0;
        #1;
        chk("arst_dac_valid", 64'(dac_valid), 64'd0);
        chk("arst_dac_data", 64'({dac_data_q2, dac_data_i2, dac_data_q1, dac_data_i1}), 64'd0);
        chk("arst_s_ready", 64'(s_ready), 64'd1);
        chk("arst_running", 64'(running), 64'd0);
        chk("arst_r1_mode", 64'(dac_r1_mode), 64'd1);
        tick(2);
        #2 rstn = 1'b1;
        tick(3);
        chk("post_rst_idle", 64'(running), 64'd0);
        for (int i = 1; i <= 8; i++) begin
            push(mk(12'(12'h300 + i), 12'h0, 12'h0, 12'h0));
            if (i == 7) chk("post_rst_not_full", 64'(s_ready), 64'd1);
            if (i == 8) chk("post_rst_full", 64'(s_ready), 64'd0);
        end
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
